// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: interval sequencer for the simple counter. Runs a table of
// thresholds back-to-back (LOAD: clear counter + latch threshold, RUN: count
// until terminal count), with step/sequence/abort pulses and a sticky irq.
module cnt_seq_ctrl #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int IdxW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            tbl_we_i,
  input  logic [IdxW-1:0] tbl_addr_i,
  input  logic [W-1:0]    tbl_wdata_i,
  input  logic [IdxW:0]   num_steps_i,
  input  logic            loop_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            irq_clr_i,
  input  logic            cnt_tc_i,
  output logic            cnt_en_o,
  output logic            cnt_clr_o,
  output logic [W-1:0]    cnt_thr_o,
  output logic            busy_o,
  output logic [IdxW-1:0] step_idx_o,
  output logic            step_done_o,
  output logic            seq_done_o,
  output logic            abort_o,
  output logic            irq_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [IdxW:0] DEPTH_C = (IdxW+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [IdxW-1:0] idx, idx_nxt;
  logic [IdxW:0]   ns_q, ns_clamp;
  logic            loop_q;
  logic            take_start;
  logic            last_step;
  logic            step_set, seq_set, abort_set;
  logic [W-1:0]    tbl [DEPTH];
  logic [W-1:0]    thr_q;
  logic            step_q, seq_q, abort_q, irq_q;

  // Width is a build-time choice; flag illegal values in simulation.
  assert property (@(posedge clk_i) (W >= 1) && (W <= 32));

  // Requested step count, clamped to the table size.
  always_comb begin
    ns_clamp = num_steps_i;
    if (num_steps_i > DEPTH_C) ns_clamp = DEPTH_C;
  end

  assign last_step = ({1'b0, idx} == (ns_q - 1'b1));

  // Next state, next index and event strobes; stop has priority over tc.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    take_start = 1'b0;
    step_set   = 1'b0;
    seq_set    = 1'b0;
    abort_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !stop_i && (ns_clamp != '0)) begin
          state_nxt  = LOAD;
          idx_nxt    = '0;
          take_start = 1'b1;
        end
      end
      LOAD: begin
        if (stop_i) begin
          state_nxt = IDLE;
          abort_set = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_nxt = IDLE;
          abort_set = 1'b1;
        end else if (cnt_tc_i) begin
          step_set = 1'b1;
          if (!last_step) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = LOAD;
          end else if (loop_q) begin
            idx_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
            seq_set   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter drive: clear in LOAD and in the IDLE cycle right after an abort.
  always_comb begin
    cnt_en_o  = 1'b0;
    cnt_clr_o = abort_q;
    busy_o    = 1'b0;
    case (state)
      LOAD: begin
        cnt_clr_o = 1'b1;
        busy_o    = 1'b1;
      end
      RUN: begin
        cnt_en_o = 1'b1;
        busy_o   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, step index and the parameters latched at start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      idx    <= '0;
      ns_q   <= '0;
      loop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (take_start) begin
        ns_q   <= ns_clamp;
        loop_q <= loop_i;
      end
    end
  end

  // Threshold table; a write lands at the next edge, so a LOAD in the same
  // cycle still sees the previous entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (tbl_we_i) begin
      tbl[tbl_addr_i] <= tbl_wdata_i;
    end
  end

  // Threshold latched at the end of LOAD and held for the whole step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) thr_q <= '0;
    else if (state == LOAD) thr_q <= tbl[idx];
  end

  // Registered event pulses; irq set (including while seq_done is showing)
  // beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q  <= 1'b0;
      seq_q   <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      step_q  <= step_set;
      seq_q   <= seq_set;
      abort_q <= abort_set;
      irq_q   <= seq_set | seq_q | (irq_q & ~irq_clr_i);
    end
  end

  assign cnt_thr_o   = thr_q;
  assign step_idx_o  = idx;
  assign step_done_o = step_q;
  assign seq_done_o  = seq_q;
  assign abort_o     = abort_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: drives cnt_seq_ctrl together with a behavioural counter
// and compares every cycle against a step-position reference model.
module tb_cnt_seq_ctrl;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int IdxW  = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tbl_we;
  logic [IdxW-1:0] tbl_addr;
  logic [W-1:0]    tbl_wdata;
  logic [IdxW:0]   num_steps;
  logic            loop_en, start, stop, irq_clr;
  logic            cnt_tc;
  logic            cnt_en, cnt_clr, busy, step_done, seq_done, abort_p, irq;
  logic [W-1:0]    cnt_thr;
  logic [IdxW-1:0] step_idx;
  logic [W-1:0]    cnt;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr),
    .tbl_wdata_i(tbl_wdata), .num_steps_i(num_steps), .loop_i(loop_en),
    .start_i(start), .stop_i(stop), .irq_clr_i(irq_clr), .cnt_tc_i(cnt_tc),
    .cnt_en_o(cnt_en), .cnt_clr_o(cnt_clr), .cnt_thr_o(cnt_thr), .busy_o(busy),
    .step_idx_o(step_idx), .step_done_o(step_done), .seq_done_o(seq_done),
    .abort_o(abort_p), .irq_o(irq)
  );

  // The counter being sequenced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_en) cnt <= cnt + 1;
  end
  assign cnt_tc = (cnt == cnt_thr);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sd_q[$];
  int seq_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a step is one LOAD cycle (pos 0) plus thr+1 RUN cycles.
  int m_tbl [DEPTH];
  bit m_busy, m_loop, m_step, m_seq, m_abort, m_irq;
  int m_idx, m_pos, m_ns, m_thr;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    m_busy = 0; m_loop = 0; m_step = 0; m_seq = 0; m_abort = 0; m_irq = 0;
    m_idx = 0; m_pos = 0; m_ns = 0; m_thr = 0;
  endtask

  task automatic model_edge();
    bit st, sq, ab;
    int ns_c;
    st = 0; sq = 0; ab = 0;
    ns_c = (int'(num_steps) > DEPTH) ? DEPTH : int'(num_steps);
    if (m_busy) begin
      if (m_pos == 0) m_thr = m_tbl[m_idx];
      if (stop) begin
        m_busy = 0; ab = 1;
      end else if (m_pos > 0 && m_pos == m_thr + 1) begin
        st = 1;
        m_pos = 0;
        if (m_idx < m_ns - 1) m_idx++;
        else if (m_loop) m_idx = 0;
        else begin m_busy = 0; sq = 1; end
      end else begin
        m_pos++;
      end
    end else if (start && !stop && ns_c != 0) begin
      m_busy = 1; m_idx = 0; m_pos = 0; m_ns = ns_c; m_loop = loop_en;
    end
    m_irq = sq || m_seq || (m_irq && !irq_clr);
    m_step = st; m_seq = sq; m_abort = ab;
    if (tbl_we) m_tbl[tbl_addr] = int'(tbl_wdata);
  endtask

  task automatic compare();
    chk("busy",      busy,      m_busy);
    chk("cnt_en",    cnt_en,    m_busy && m_pos != 0);
    chk("cnt_clr",   cnt_clr,   (m_busy && m_pos == 0) || m_abort);
    chk("cnt_thr",   cnt_thr,   m_thr);
    chk("step_idx",  step_idx,  m_idx);
    chk("step_done", step_done, m_step);
    chk("seq_done",  seq_done,  m_seq);
    chk("abort",     abort_p,   m_abort);
    chk("irq",       irq,       m_irq);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare();
    if (step_done) sd_q.push_back(cyc);
    if (seq_done)  seq_q.push_back(cyc);
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {cnt_en, cnt_clr, busy, step_done, seq_done, abort_p, irq}, 0);
    chk({tag, "_thr"}, cnt_thr, 0);
    chk({tag, "_idx"}, step_idx, 0);
  endtask

  task automatic wr(input int a, input int d);
    tbl_we = 1; tbl_addr = IdxW'(a); tbl_wdata = W'(d);
    tick();
    tbl_we = 0;
  endtask

  task automatic go(input int ns, input bit lp, output int s);
    num_steps = (IdxW+1)'(ns); loop_en = lp; start = 1;
    sd_q.delete(); seq_q.delete();
    s = cyc;
    tick();
    start = 0;
  endtask

  initial begin
    int s;
    rst_n = 0; tbl_we = 0; tbl_addr = '0; tbl_wdata = '0; num_steps = '0;
    loop_en = 0; start = 0; stop = 0; irq_clr = 0;
    model_reset();
    #23;
    chk_all_zero("reset");
    @(posedge clk); #1; rst_n = 1;
    repeat (2) tick();

    // single shot {3,5}; irq_clr during the seq_done cycle must not win
    wr(0, 3); wr(1, 5);
    go(2, 0, s);
    for (int n = 1; n <= 16; n++) begin
      irq_clr = (n == 13);
      tick();
    end
    irq_clr = 0;
    chk("ss_nsd", sd_q.size(), 2);
    if (sd_q.size() == 2) begin
      chk("ss_sd0", sd_q[0] - s, 5);
      chk("ss_sd1", sd_q[1] - s, 12);
    end
    chk("ss_nseq", seq_q.size(), 1);
    if (seq_q.size() == 1) chk("ss_seq", seq_q[0] - s, 12);
    chk("ss_irq_hold", irq, 1);
    chk("ss_busy", busy, 0);
    irq_clr = 1; tick(); irq_clr = 0;
    chk("irq_clr", irq, 0);

    // loop {1,2}
    wr(0, 1); wr(1, 2);
    go(2, 1, s);
    repeat (20) tick();
    chk("lp_nsd", sd_q.size(), 5);
    if (sd_q.size() > 0) chk("lp_first", sd_q[0] - s, 3);
    for (int i = 1; i < sd_q.size(); i++)
      chk("lp_gap", sd_q[i] - sd_q[i-1], (i % 2 == 1) ? 4 : 3);
    chk("lp_nseq", seq_q.size(), 0);
    stop = 1; tick(); stop = 0;
    chk("lp_abort", abort_p, 1);
    chk("lp_abclr", cnt_clr, 1);
    chk("lp_abbusy", busy, 0);
    tick();
    chk("lp_abort_1cyc", abort_p, 0);
    chk("lp_clr_1cyc", cnt_clr, 0);

    // stop together with terminal count
    wr(0, 3);
    go(1, 0, s);
    repeat (4) tick();
    chk("ab_tc_high", cnt_tc, 1);
    stop = 1; tick(); stop = 0;
    chk("ab_abort", abort_p, 1);
    chk("ab_nostep", step_done, 0);
    chk("ab_clr", cnt_clr, 1);
    chk("ab_busy", busy, 0);
    repeat (3) tick();
    chk("ab_nsd", sd_q.size(), 0);

    // num_steps = 0 is ignored
    go(0, 0, s);
    repeat (5) tick();
    chk("ns0_busy", busy, 0);
    chk("ns0_nsd", sd_q.size(), 0);

    // num_steps = DEPTH+3 with all-zero thresholds: DEPTH two-cycle steps
    for (int i = 0; i < DEPTH; i++) wr(i, 0);
    go(DEPTH + 3, 0, s);
    repeat (24) tick();
    chk("clamp_nsd", sd_q.size(), DEPTH);
    chk("clamp_nseq", seq_q.size(), 1);
    if (sd_q.size() > 0) chk("t0_first", sd_q[0] - s, 2);
    for (int i = 1; i < sd_q.size(); i++) chk("t0_gap", sd_q[i] - sd_q[i-1], 2);

    // rewrite current and next entry while busy
    wr(0, 4); wr(1, 4);
    go(2, 0, s);
    repeat (2) tick();
    wr(0, 1); wr(1, 2);
    repeat (14) tick();
    chk("wb_nsd", sd_q.size(), 2);
    if (sd_q.size() == 2) begin
      chk("wb_sd0", sd_q[0] - s, 6);
      chk("wb_sd1", sd_q[1] - s, 10);
    end

    // async reset mid-RUN, then a clean run
    wr(0, 5);
    go(1, 0, s);
    repeat (3) tick();
    #3 rst_n = 0;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    tick();
    wr(0, 2);
    go(1, 0, s);
    repeat (6) tick();
    chk("rst_nsd", sd_q.size(), 1);
    if (sd_q.size() == 1) chk("rst_sd0", sd_q[0] - s, 4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tbl_we    = ($urandom_range(3) == 0);
      tbl_addr  = IdxW'($urandom_range(DEPTH - 1));
      tbl_wdata = W'($urandom_range(5));
      num_steps = (IdxW+1)'($urandom_range(2*DEPTH - 1));
      loop_en   = ($urandom_range(3) == 0);
      start     = ($urandom_range(7) == 0);
      stop      = ($urandom_range(39) == 0);
      irq_clr   = ($urandom_range(15) == 0);
      tick();
    end
    tbl_we = 0; start = 0; stop = 0; irq_clr = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Interval sequencer for the simple counter. It holds a table of up to DEPTH thresholds and drives the counter's enable, clear and threshold inputs to run them back-to-back, one interval per entry. It reports per-step and end-of-sequence events and supports single-shot or looping runs. It sits between the user-domain control logic and the counter, replacing the register-file drive of en/clr/thr when sequencing is in use.

## Interface
- W, 32: counter and threshold width, legal range [1,32]; checked by a simulation-only assertion.
- DEPTH, 8: number of table entries; must be a power of 2, ≥2. IdxW = $clog2(DEPTH).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tbl_we_i  in  1  table write strobe.
- tbl_addr_i  in  IdxW  table write address.
- tbl_wdata_i  in  W  threshold written to the table.
- num_steps_i  in  IdxW+1  number of steps in the sequence; values above DEPTH are clamped to DEPTH.
- loop_i  in  1  1 = restart at entry 0 after the last step.
- start_i  in  1  start pulse.
- stop_i  in  1  abort pulse.
- irq_clr_i  in  1  clears irq_o.
- cnt_tc_i  in  1  counter terminal count; a level, high while counter value == cnt_thr_o.
- cnt_en_o  out  1  counter enable.
- cnt_clr_o  out  1  counter synchronous clear.
- cnt_thr_o  out  W  counter threshold (registered).
- busy_o  out  1  sequence active.
- step_idx_o  out  IdxW  index of the current step.
- step_done_o  out  1  one-cycle pulse at the end of each step.
- seq_done_o  out  1  one-cycle pulse at the end of a non-looping sequence.
- abort_o  out  1  one-cycle pulse when stop_i ends an active sequence.
- irq_o  out  1  sticky interrupt; set by seq_done_o, cleared by irq_clr_i.

## Operation
- Table: DEPTH×W flops, reset to 0. A write takes effect at the next clock. Writes are allowed while busy. A write changes only steps loaded after it; the active cnt_thr_o is not changed.
- num_steps_i and loop_i are sampled into internal registers at start and ignored afterwards.
- FSM states are IDLE, LOAD and RUN.
- IDLE:
  - Outputs: cnt_en_o=0, cnt_clr_o=0, busy_o=0.
  - Transition: start_i with clamped num_steps ≠ 0 → LOAD, idx=0.
  - start_i with num_steps = 0 is ignored.
- LOAD (exactly 1 cycle):
  - Outputs: cnt_clr_o=1, cnt_en_o=0, busy_o=1.
  - cnt_thr_o is loaded with tbl[idx] at the end of the cycle.
  - cnt_tc_i is ignored in this state.
  - Transition: → RUN.
- RUN:
  - Outputs: cnt_en_o=1, busy_o=1.
  - On cnt_tc_i=1: step_done_o pulses in that cycle. Then:
    - idx < num_steps−1 → idx+1, LOAD.
    - Last step with loop=1 → idx=0, LOAD.
    - Last step with loop=0 → IDLE, seq_done_o pulses, irq_o set.
- stop_i in LOAD or RUN → IDLE next cycle.
  - abort_o pulses, and cnt_clr_o pulses for 1 cycle in the following IDLE cycle.
  - No step_done_o or seq_done_o.
  - stop_i in IDLE has no effect.
- Simultaneous events:
  - stop_i and start_i together: stop wins (in IDLE, both are ignored).
  - stop_i together with cnt_tc_i in RUN: abort only, no step_done_o.
  - start_i while busy is ignored.
  - irq_o set and irq_clr_i in the same cycle: set wins.
- step_idx_o = idx register; it holds its last value in IDLE until the next start.

## Timing
- Reset values:
  - All outputs 0: cnt_en_o, cnt_clr_o, cnt_thr_o, busy_o, step_idx_o, step_done_o, seq_done_o, abort_o, irq_o.
  - State = IDLE, idx = 0, table = 0.
- start_i sampled at edge k → LOAD in cycle k+1 → RUN from cycle k+2.
- The counter is 0 in the first RUN cycle and increments once per enabled cycle. With threshold T, cnt_tc_i is seen in the (T+1)th RUN cycle.
- Step period = T+2 cycles (1 LOAD + T+1 RUN). A looping sequence has no extra gap between steps.
- T=0: cnt_tc_i is seen in the first RUN cycle; the step lasts 2 cycles.
- step_done_o and seq_done_o are registered pulses, asserted in the cycle after the RUN cycle in which cnt_tc_i is seen.
- irq_o rises in the same cycle as seq_done_o.
- Asynchronous reset mid-sequence returns the block to the reset values immediately. The counter is left disabled (cnt_en_o=0).

## Test plan
- Single shot:
  - Stimulus: table = {3,5}, num_steps=2, loop=0, start.
  - Required: step_done_o at cycles 5 and 12 after start (periods 5 and 7); seq_done_o and irq_o at cycle 12; busy_o low afterwards.
- Loop:
  - Stimulus: table = {1,2}, num_steps=2, loop=1, run 20 cycles.
  - Required: step_idx_o sequence 0,1,0,1…; step_done_o every 3 and 4 cycles alternately; no seq_done_o.
- Abort:
  - Stimulus: stop_i in RUN, including the same cycle as cnt_tc_i.
  - Required: abort_o=1 for one cycle, cnt_clr_o=1 for one cycle, no step_done_o, busy_o=0.
- Boundaries:
  - num_steps=0 start → no activity.
  - num_steps=DEPTH+3 → exactly DEPTH steps.
  - T=0 entry → 2-cycle step.
- Table write while busy:
  - Stimulus: rewrite the current and the next entry.
  - Required: the current step keeps its old threshold; the next step uses the new one.
- irq and reset:
  - irq_clr_i together with seq_done_o → irq_o stays 1.
  - rst_ni low mid-RUN → all outputs 0 immediately; a later start runs correctly.
